// File: rtl/dbg_av_uart_tx_pkg.sv
// Shared constants and TX state encoding for the debug Avalon-MM UART transmitter.
// The PARITY state exists only when DBG_UART_PARITY_EN is defined.
package dbg_av_uart_tx_pkg;

  localparam logic [15:0] DBG_UART_ADDR_WORD = 16'h0000;
  localparam logic [15:0] DBG_UART_ADDR_BYTE = 16'h0001;
  localparam int          DBG_UART_ENTRY_W   = 17;

`ifdef DBG_UART_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;
`endif

endpackage

// File: rtl/dbg_av_uart_tx_fifo.sv
// Single-clock FIFO with registered occupancy; head entry is visible on o_dout while non-empty.
module dbg_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/dbg_av_uart_tx.sv
// Avalon-MM write-only UART transmitter for debug output: word/byte entries queued in a FIFO.
// Define DBG_UART_PARITY_EN to add an even-parity bit after the data bits.
module dbg_av_uart_tx
  import dbg_av_uart_tx_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sysclk,
  input  logic                          sysreset,
  input  logic [15:0]                   av_address,
  input  logic [15:0]                   av_writedata,
  input  logic                          av_write,
  output logic                          av_waitrequest,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

  logic                        w_addr_ok;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_empty;
  logic [DBG_UART_ENTRY_W-1:0] w_din;
  logic [DBG_UART_ENTRY_W-1:0] w_head;

  assign w_addr_ok      = (av_address == DBG_UART_ADDR_WORD) || (av_address == DBG_UART_ADDR_BYTE);
  assign w_push         = av_write && !w_full && w_addr_ok && !sysreset;
  assign w_din          = {(av_address == DBG_UART_ADDR_WORD), av_writedata};
  assign av_waitrequest = w_full;

  dbg_sync_fifo #(
    .WIDTH (DBG_UART_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (sysclk),
    .i_rst   (sysreset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  tx_state_t   r_state;
  tx_state_t   w_next;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_lo;
  logic        r_pend;
  logic        w_bit_done;
  logic        w_load;
  logic [7:0]  w_load_byte;
  logic [7:0]  w_load_lo;
  logic        w_load_pend;
  logic        w_tx;

  assign w_bit_done = (r_baud == 16'd0);
  assign uart_tx    = w_tx;
  assign tx_busy    = !w_empty || (r_state != TX_IDLE);

  // Word entries send the high byte first and park the low byte in r_lo.
  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_load_byte = r_lo;
    w_load_lo   = r_lo;
    w_load_pend = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      TX_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_load = 1'b1;
          w_next = TX_START;
          if (w_head[16]) begin
            w_load_byte = w_head[15:8];
            w_load_lo   = w_head[7:0];
            w_load_pend = 1'b1;
          end else begin
            w_load_byte = w_head[7:0];
          end
        end
      end
      TX_START: begin
        w_tx = 1'b0;
        if (w_bit_done) w_next = TX_DATA;
      end
      TX_DATA: begin
        w_tx = r_shift[r_bit];
        if (w_bit_done && (r_bit == 3'd7)) begin
`ifdef DBG_UART_PARITY_EN
          w_next = TX_PARITY;
`else
          w_next = TX_STOP;
`endif
        end
      end
`ifdef DBG_UART_PARITY_EN
      TX_PARITY: begin
        w_tx = ^r_shift;
        if (w_bit_done) w_next = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (w_bit_done) begin
          if (r_pend) begin
            w_next = TX_START;
            w_load = 1'b1;
          end else begin
            w_next = TX_IDLE;
          end
        end
      end
      default: w_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      r_state <= TX_IDLE;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == TX_IDLE) || w_bit_done) r_baud <= BAUD_RELOAD;
      else                                    r_baud <= r_baud - 16'd1;
      if (r_state != TX_DATA) r_bit <= 3'd0;
      else if (w_bit_done)    r_bit <= r_bit + 3'd1;
      if (w_load) r_pend <= w_load_pend;
    end
  end

  always_ff @(posedge sysclk) begin
    if (w_load) begin
      r_shift <= w_load_byte;
      r_lo    <= w_load_lo;
    end
  end

endmodule

// File: tb/tb_dbg_av_uart_tx.sv
// Directed bench for dbg_av_uart_tx with BAUD_DIV=4, FIFO_DEPTH=4; follows DBG_UART_PARITY_EN.
module tb_dbg_av_uart_tx;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
`ifdef DBG_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * BAUD;
  localparam int RX_TAIL   = (FRAME_BITS - 1) * BAUD + 2 - 34;

  logic        sysclk = 1'b0;
  logic        sysreset = 1'b1;
  logic [15:0] av_address = 16'h0;
  logic [15:0] av_writedata = 16'h0;
  logic        av_write = 1'b0;
  logic        av_waitrequest;
  logic        uart_tx;
  logic        tx_busy;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rx_q[$];

  dbg_av_uart_tx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk         (sysclk),
    .sysreset       (sysreset),
    .av_address     (av_address),
    .av_writedata   (av_writedata),
    .av_write       (av_write),
    .av_waitrequest (av_waitrequest),
    .uart_tx        (uart_tx),
    .tx_busy        (tx_busy),
    .fifo_count     (fifo_count)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic do_write(input logic [15:0] addr, input logic [15:0] data, output int rej);
    rej = 0;
    av_address   = addr;
    av_writedata = data;
    av_write     = 1'b1;
    while (av_waitrequest !== 1'b0 && rej < 200) begin
      @(negedge sysclk);
      rej++;
    end
    if (rej >= 200) check_val("write_timeout", rej, 0);
    @(negedge sysclk);
    av_write = 1'b0;
  endtask

  // Called at the negedge of the first start-bit cycle; checks every cycle of the frame.
  task automatic expect_frame(input logic [7:0] b);
    logic [10:0] fr;
    fr = 11'h7FF;
    fr[0] = 1'b0;
    fr[8:1] = b;
`ifdef DBG_UART_PARITY_EN
    fr[9] = ^b;
`endif
    for (int i = 0; i < FRAME_BITS; i++) begin
      for (int c = 0; c < BAUD; c++) begin
        check_val($sformatf("frame_%02h_bit%0d", b, i), uart_tx, fr[i]);
        @(negedge sysclk);
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (tx_busy !== 1'b0 && w < 2000) begin
      @(negedge sysclk);
      w++;
    end
    check_val("drain_done", (w < 2000), 1);
    repeat (4) @(negedge sysclk);
  endtask

  initial begin : rx
    logic [7:0] b;
    b = 8'h0;
    forever begin
      @(negedge sysclk);
      if (uart_tx === 1'b0 && sysreset === 1'b0) begin
        repeat (6) @(negedge sysclk);
        for (int k = 0; k < 8; k++) begin
          b[k] = uart_tx;
          if (k < 7) repeat (4) @(negedge sysclk);
        end
        repeat (RX_TAIL) @(negedge sysclk);
        rx_q.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int rej;
    logic all_high;
    logic [7:0] six[6];
    logic [7:0] four[4];
    six  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    four = '{8'hC3, 8'h5A, 8'h81, 8'h7E};

    repeat (3) @(negedge sysclk);
    sysreset = 1'b0;
    check_val("rst_uart_tx", uart_tx, 1);
    check_val("rst_waitreq", av_waitrequest, 0);
    check_val("rst_busy", tx_busy, 0);
    check_val("rst_count", fifo_count, 0);
    repeat (2) @(negedge sysclk);

    // Single byte 0x55
    do_write(16'h0001, 16'h0055, rej);
    check_val("byte_rej", rej, 0);
    check_val("byte_n1_high", uart_tx, 1);
    check_val("byte_n1_count", fifo_count, 1);
    check_val("byte_n1_busy", tx_busy, 1);
    @(negedge sysclk);
    expect_frame(8'h55);
    check_val("byte_idle_tx", uart_tx, 1);
    check_val("byte_idle_busy", tx_busy, 0);
    repeat (3) @(negedge sysclk);

    // Word 0xA13C: high byte then low byte back to back
    do_write(16'h0000, 16'hA13C, rej);
    check_val("word_n1_high", uart_tx, 1);
    @(negedge sysclk);
    expect_frame(8'hA1);
    expect_frame(8'h3C);
    check_val("word_idle_busy", tx_busy, 0);
    repeat (3) @(negedge sysclk);

    // Six back-to-back byte writes into a 4-deep FIFO
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      do_write(16'h0001, {8'h00, six[i]}, rej);
      check_val($sformatf("six_rej%0d", i), rej, 0);
    end
    check_val("six_waitreq", av_waitrequest, 1);
    check_val("six_count_full", fifo_count, 4);
    do_write(16'h0001, {8'h00, six[5]}, rej);
    check_val("six_held_cycles", rej, FRAME_CYC - 2);
    check_val("six_count_after", fifo_count, 4);
    drain();
    check_val("six_rx_size", rx_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < rx_q.size()) check_val($sformatf("six_rx%0d", i), rx_q[i], six[i]);

    // Unmapped address is accepted and dropped
    do_write(16'h0002, 16'hFFFF, rej);
    check_val("bad_rej", rej, 0);
    check_val("bad_count", fifo_count, 0);
    all_high = 1'b1;
    for (int i = 0; i < 12; i++) begin
      all_high &= uart_tx & ~tx_busy;
      @(negedge sysclk);
    end
    check_val("bad_line_idle", all_high, 1);

    // Reset during DATA of a word, with a write presented during reset
    do_write(16'h0000, 16'hA13C, rej);
    repeat (12) @(negedge sysclk);
    check_val("abort_in_frame", tx_busy, 1);
    sysreset     = 1'b1;
    av_address   = 16'h0001;
    av_writedata = 16'h0077;
    av_write     = 1'b1;
    @(negedge sysclk);
    sysreset = 1'b0;
    av_write = 1'b0;
    check_val("abort_tx", uart_tx, 1);
    check_val("abort_count", fifo_count, 0);
    check_val("abort_busy", tx_busy, 0);
    all_high = 1'b1;
    for (int i = 0; i < 50; i++) begin
      all_high &= uart_tx;
      @(negedge sysclk);
    end
    check_val("abort_stays_idle", all_high, 1);
    check_val("abort_count_late", fifo_count, 0);
    rx_q.delete();
    do_write(16'h0001, 16'h000F, rej);
    check_val("post_abort_n1", uart_tx, 1);
    @(negedge sysclk);
    expect_frame(8'h0F);
    check_val("post_abort_busy", tx_busy, 0);
    repeat (3) @(negedge sysclk);

    // Push and pop in the same cycle with two entries queued
    rx_q.delete();
    do_write(16'h0001, {8'h00, four[0]}, rej);
    do_write(16'h0001, {8'h00, four[1]}, rej);
    do_write(16'h0001, {8'h00, four[2]}, rej);
    check_val("pp_count_pre", fifo_count, 2);
    repeat (FRAME_CYC - 1) @(negedge sysclk);
    check_val("pp_count_before", fifo_count, 2);
    do_write(16'h0001, {8'h00, four[3]}, rej);
    check_val("pp_rej", rej, 0);
    check_val("pp_count_after", fifo_count, 2);
    drain();
    check_val("pp_rx_size", rx_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) check_val($sformatf("pp_rx%0d", i), rx_q[i], four[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dbg_av_uart_tx.md
DBG_AV_UART_TX -- requirements
Module: dbg_av_uart_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434, sysclk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, entry count; power of 2, at least 2.
REQ-003 SHALL have port sysclk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port sysreset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port av_address  input  16  Avalon-MM slave address, driven by the debugging supervisor's dbg_av_address.
REQ-006 SHALL have port av_writedata  input  16  write data.
REQ-007 SHALL have port av_write  input  1  write strobe.
REQ-008 SHALL have port av_waitrequest  output  1  stall; high when FIFO full.
REQ-009 SHALL have port uart_tx  output  1  serial line, idle high.
REQ-010 SHALL have port tx_busy  output  1  high while FIFO non-empty or a frame is in flight.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  registered occupancy.

Function
REQ-012 SHALL accept a write in any cycle with av_write=1 and av_waitrequest=0.
REQ-013 SHALL push {1'b1, av_writedata} for address 0x0000 (word entry: high byte sent, then low byte).
REQ-014 SHALL push {1'b0, av_writedata} for address 0x0001 (byte entry: low byte only).
REQ-015 SHALL accept and discard writes to any other address, with no push and no stall.
REQ-016 SHALL drive av_waitrequest = (fifo_count == FIFO_DEPTH), from registered state only.
REQ-017 SHALL keep fifo_count unchanged on simultaneous push and pop; a push into a full FIFO cannot occur.
REQ-018 SHALL implement TX FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE: if FIFO non-empty, SHALL pop the head and enter START next cycle; uart_tx goes low the cycle START is entered.
REQ-020 SHALL hold each bit for exactly BAUD_DIV cycles, counted by a 16-bit down-counter.
REQ-021 SHALL transmit the frame as start(0), 8 data bits LSB first, optional parity, stop(1).
REQ-022 For a word entry, after the high-byte STOP SHALL go directly to START for the low byte, without an IDLE cycle.
REQ-023 After the final byte's STOP SHALL spend at least one cycle in IDLE.
REQ-024 SHALL clear the bit-index counter to 0 on entering DATA and wrap it 7 -> exit.
REQ-025 Acceptance at cycle N into an empty FIFO with the FSM idle SHALL produce the start-bit edge at cycle N+2.

Reset
REQ-026 On sysreset SHALL return FSM to IDLE, empty the FIFO, and clear the bit and baud counters.
REQ-027 Reset values: uart_tx=1, av_waitrequest=0, tx_busy=0, fifo_count=0.
REQ-028 Reset mid-frame SHALL abort the frame, with uart_tx high the cycle after reset is sampled; partial bytes are not resumed.
REQ-029 Writes presented while sysreset=1 SHALL be discarded.

Configuration
REQ-030 With DBG_UART_PARITY_EN defined, SHALL insert PARITY state carrying an even-parity bit (XOR of the 8 data bits); frame length 11*BAUD_DIV.
REQ-031 Without DBG_UART_PARITY_EN, PARITY state and logic SHALL be absent; STOP follows DATA; frame length 10*BAUD_DIV.

Structure
REQ-032 Shared package SHALL hold address constants DBG_UART_ADDR_WORD=0x0000 and DBG_UART_ADDR_BYTE=0x0001, plus the TX state encoding.
REQ-033 FIFO SHALL be a separate sub-module dbg_sync_fifo (17-bit wide, FIFO_DEPTH deep, single clock, push/pop/full/empty/count).

Verification (bench BAUD_DIV=4, FIFO_DEPTH=4)
REQ-034 Byte write addr 0x0001 data 0x0055 -> uart_tx low at N+2, then bits 1,0,1,0,1,0,1,0 each 4 cycles, then stop high; 40 cycles total (44 with parity, parity bit 0).
REQ-035 Word write addr 0x0000 data 0xA13C -> byte 0xA1 then 0x3C back-to-back, 80 cycles with no idle between bytes.
REQ-036 Six back-to-back byte writes -> entry 1 popped at once; av_waitrequest high after 5 accepted writes; 6th held until first pop after a frame; all 6 bytes emitted in order.
REQ-037 Write to addr 0x0002 data 0xFFFF -> accepted in one cycle, fifo_count stays 0, uart_tx stays high.
REQ-038 sysreset asserted during DATA of a word -> next cycle uart_tx=1, fifo_count=0, tx_busy=0; a following byte write 0x0F emits one clean frame.
REQ-039 Push and pop in the same cycle with count 2 -> fifo_count stays 2; data order preserved.
